dcache_wb_dm: RTL and testbench
===============================

# dcache_wb_dm

Direct-mapped, write-back, write-allocate data cache between the pipeline's MEM stage (DCACHE_* port) and the main-memory line interface. It serves single-cycle word hits and stalls the pipeline through `proc_stall` while it writes back dirty victims and refills 128-bit lines. It also serves as the I-cache instance when writes are tied low.

## Interface
Parameters:
- NUM_LINES, 8, number of cache lines. Must be a power of two, minimum 2. INDEX_W = log2(NUM_LINES).

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- proc_reset  in  1  synchronous, active-high reset
- proc_read  in  1  word read request
- proc_write  in  1  word write request; if asserted together with proc_read, the request is a write
- proc_addr  in  30  word address: offset [1:0], index [INDEX_W+1:2], tag [29:INDEX_W+2]
- proc_wdata  in  32  write data
- proc_rdata  out  32  read data; valid when proc_stall=0 and proc_read=1
- proc_stall  out  1  combinational; high while a request is not yet satisfied
- mem_read  out  1  line refill request
- mem_write  out  1  line write-back request
- mem_addr  out  28  line address ({tag,index})
- mem_wdata  out  128  victim line; word k at [32k+31:32k]
- mem_rdata  in  128  refill line, same word order
- mem_ready  in  1  one-cycle pulse marking completion of the current mem_read or mem_write

## Operation
- Per-line storage: valid, dirty, tag, and a 128-bit data line. Data and tags are flops; no SRAM macro.
- Hit condition: valid[index] && tag[index]==addr tag.
- State COMPARE (reset state):
  - No request: proc_stall=0, no state change.
  - Read hit: proc_rdata = word[offset], proc_stall=0.
  - Write hit: proc_stall=0. On the edge, word[offset] <= proc_wdata and dirty <= 1.
  - Miss, victim clean or invalid: proc_stall=1, next state ALLOCATE.
  - Miss, victim valid and dirty: proc_stall=1, next state WRITEBACK.
- WRITEBACK:
  - Outputs: mem_write=1, mem_addr={stored tag,index}, mem_wdata=stored line.
  - proc_stall=1.
  - On mem_ready, go to ALLOCATE.
- ALLOCATE:
  - Outputs: mem_read=1, mem_addr=proc_addr[29:2], proc_stall=1.
  - On mem_ready: line <= mem_rdata, tag <= addr tag, valid <= 1, dirty <= 0, go to COMPARE.
  - The pending request then resolves in COMPARE as a hit. A write merges there and sets dirty.
- mem_read and mem_write are Moore outputs of state only. They are never both high. mem_addr and mem_wdata stay constant while either is asserted.
- mem_ready is ignored in COMPARE.
- Upstream contract: proc_read, proc_write, proc_addr and proc_wdata are held stable while proc_stall=1. This is not checked.

## Timing
- Reset values:
  - state=COMPARE; all valid and dirty bits = 0.
  - mem_read=0, mem_write=0.
  - proc_stall=0 when no request.
  - mem_addr, mem_wdata and proc_rdata are don't-care but free of X after reset.
  - Tags and data are not reset.
- Hit: 0 stall cycles.
- Clean miss: 1 COMPARE cycle, then ALLOCATE until mem_ready, then 1 COMPARE cycle with stall low. Total stall = 1 + refill latency.
- Dirty miss: adds the WRITEBACK duration before ALLOCATE.
- Reset asserted in any state: on that edge, return to COMPARE and invalidate all lines. mem_read and mem_write are low in the following cycle. An in-flight memory transaction is abandoned.
- Conflict: two addresses with equal index and different tag evict each other. Index wrap at NUM_LINES is inherent in the address split.

## Test plan
- Reset, then read proc_addr=0x0000_0003:
  - Expect proc_stall=1 and mem_read=1 with mem_addr=0.
  - Return mem_ready 3 cycles later with mem_rdata=128'h4444_4444_3333_3333_2222_2222_1111_1111.
  - Next cycle: proc_stall=0, proc_rdata=0x4444_4444.
- After the above, write 0xDEAD_BEEF to 0x0000_0001:
  - Expect no stall.
  - A read of 0x0000_0001 returns 0xDEAD_BEEF with no stall.
  - mem_read and mem_write stay 0.
- Then read 0x0000_0021 (index 0, tag 1; dirty conflict, NUM_LINES=8):
  - Expect mem_write=1, mem_addr=0x000_0000, mem_wdata=128'h4444_4444_3333_3333_DEAD_BEEF_1111_1111.
  - After mem_ready: mem_read=1, mem_addr=0x000_0008.
  - After refill, proc_rdata = word 1 of the new line.
- Idle for 10 cycles with proc_read=proc_write=0: expect proc_stall=0, mem_read=mem_write=0.
- Assert proc_reset during WRITEBACK: mem_write=0 next cycle, and the following read of 0x0000_0001 misses with mem_read and mem_addr=0.
- Write miss to 0x0000_0042 with proc_wdata=0x1234_5678:
  - Refill, then the merge cycle has stall low.
  - A subsequent conflicting miss writes back a line whose word 2 = 0x1234_5678.

Source files
------------

// File: rtl/dcache_wb_dm.sv
// Direct-mapped write-back, write-allocate data cache with 128-bit line refill/write-back.
// Single-cycle word hits; proc_stall holds the pipeline across victim write-back and refill.
module dcache_wb_dm #(
    parameter int unsigned NUM_LINES = 8
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);
    localparam int unsigned INDEX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W   = 28 - INDEX_W;

    typedef enum logic [1:0] {S_COMPARE, S_WRITEBACK, S_ALLOCATE} state_e;

    state_e               state_q, state_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [127:0]         data_q [NUM_LINES];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   addr_tag;
    logic [1:0]         off;
    logic [TAG_W-1:0]   cur_tag;
    logic [127:0]       cur_line;
    logic               hit;
    logic               req;
    logic               line_we;
    logic               tag_we;
    logic [127:0]       line_wdata;

    assign idx      = proc_addr[INDEX_W+1:2];
    assign addr_tag = proc_addr[29:INDEX_W+2];
    assign off      = proc_addr[1:0];
    assign cur_tag  = tag_q[idx];
    assign cur_line = data_q[idx];
    assign hit      = valid_q[idx] && (cur_tag == addr_tag);
    assign req      = proc_read | proc_write;

    // Next-state, array updates and all (Moore + request-dependent) outputs
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        line_we    = 1'b0;
        tag_we     = 1'b0;
        line_wdata = cur_line;
        proc_stall = 1'b0;
        proc_rdata = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = proc_addr[29:2];
        mem_wdata  = '0;
        case (state_q)
            S_COMPARE: begin
                if (req) begin
                    if (hit) begin
                        if (proc_write) begin
                            line_we                      = 1'b1;
                            line_wdata[{off, 5'd0} +: 32] = proc_wdata;
                            dirty_d[idx]                 = 1'b1;
                        end else begin
                            proc_rdata = cur_line[{off, 5'd0} +: 32];
                        end
                    end else begin
                        proc_stall = 1'b1;
                        state_d    = (valid_q[idx] && dirty_q[idx]) ? S_WRITEBACK : S_ALLOCATE;
                    end
                end
            end
            S_WRITEBACK: begin
                mem_write  = 1'b1;
                mem_addr   = {cur_tag, idx};
                mem_wdata  = cur_line;
                proc_stall = 1'b1;
                if (mem_ready) begin
                    state_d = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                mem_read   = 1'b1;
                proc_stall = 1'b1;
                if (mem_ready) begin
                    line_we      = 1'b1;
                    line_wdata   = mem_rdata;
                    tag_we       = 1'b1;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                    state_d      = S_COMPARE;
                end
            end
            default: state_d = S_COMPARE;
        endcase
    end

    // Control state: reset invalidates every line and abandons any memory transaction
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q <= S_COMPARE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data arrays are plain flops without reset; valid bits guard them
    always_ff @(posedge clk) begin
        if (line_we) begin
            data_q[idx] <= line_wdata;
        end
        if (tag_we) begin
            tag_q[idx] <= addr_tag;
        end
    end
endmodule

// File: tb/tb_dcache_wb_dm.sv
// Bench for dcache_wb_dm: directed vector table, reset-in-write-back sequence,
// then random traffic checked against a flat processor-visible memory model.
module tb_dcache_wb_dm;
    localparam int unsigned NUM_LINES = 8;

    logic         clk = 1'b0;
    logic         proc_reset = 1'b0;
    logic         proc_read = 1'b0;
    logic         proc_write = 1'b0;
    logic [29:0]  proc_addr = '0;
    logic [31:0]  proc_wdata = '0;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    dcache_wb_dm #(.NUM_LINES(NUM_LINES)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // One request: drives it, plays the memory side, checks stall length and results
    task automatic access(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] wd,
                          input int lwb, input int lrf, input logic [127:0] rfd,
                          input int exp_stall, input logic chk_rd, input logic [31:0] exp_rd,
                          input logic exp_wb, input logic [27:0] exp_wb_a, input logic [127:0] exp_wb_d);
        int stalls;
        int wbc;
        int rfc;
        logic saw_wb;
        @(posedge clk); #1;
        proc_read  = rd;
        proc_write = wr;
        proc_addr  = a;
        proc_wdata = wd;
        stalls = 0;
        wbc    = 0;
        rfc    = 0;
        saw_wb = 1'b0;
        forever begin
            @(negedge clk);
            if (!proc_stall) break;
            stalls++;
            if (stalls > 100) begin
                chk("stall_timeout", 128'(stalls), 128'(exp_stall));
                break;
            end
            if (mem_read && mem_write) chk("rd_wr_both", 128'({mem_read, mem_write}), 128'b0);
            if (mem_write) begin
                if (wbc == 0) begin
                    saw_wb = 1'b1;
                    if (exp_wb) begin
                        chk("wb_addr", 128'(mem_addr), 128'(exp_wb_a));
                        chk("wb_data", mem_wdata, exp_wb_d);
                    end
                end
                wbc++;
                if (wbc == lwb) mem_ready = 1'b1;
            end else if (mem_read) begin
                if (rfc == 0) chk("rf_addr", 128'(mem_addr), 128'(a[29:2]));
                rfc++;
                if (rfc == lrf) begin
                    mem_ready = 1'b1;
                    mem_rdata = rfd;
                end
            end
            @(posedge clk); #1;
            mem_ready = 1'b0;
        end
        chk("stall_cycles", 128'(stalls), 128'(exp_stall));
        chk("wb_seen", 128'(saw_wb), 128'(exp_wb));
        chk("mem_idle_done", 128'({mem_read, mem_write}), 128'b0);
        if (chk_rd) chk("rdata", 128'(proc_rdata), 128'(exp_rd));
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = 30'($urandom);
        @(negedge clk);
        chk("idle", 128'({proc_stall, mem_read, mem_write}), 128'b0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        proc_reset = 1'b1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        proc_reset = 1'b0;
    endtask

    typedef struct {
        logic         rd;
        logic         wr;
        logic [29:0]  addr;
        logic [31:0]  wd;
        int           lwb;
        int           lrf;
        logic [127:0] rfd;
        int           stall;
        logic         chk_rd;
        logic [31:0]  rdata;
        logic         wb;
        logic [27:0]  wb_a;
        logic [127:0] wb_d;
    } vec_t;

    vec_t tbl [8];

    // Reference model: processor-visible lines, backing memory lines, and which lines are cached
    logic [127:0] truth   [logic [27:0]];
    logic [127:0] backing [logic [27:0]];
    bit           mv   [NUM_LINES];
    bit           md   [NUM_LINES];
    logic [24:0]  mtag [NUM_LINES];

    task automatic model_clear();
        truth.delete();
        backing.delete();
        for (int i = 0; i < NUM_LINES; i++) begin
            mv[i]   = 1'b0;
            md[i]   = 1'b0;
            mtag[i] = '0;
        end
    endtask

    task automatic rand_access(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] wd);
        logic [27:0]  line;
        logic [27:0]  victim;
        logic [2:0]   idx;
        logic [24:0]  tag;
        logic [1:0]   off;
        logic [127:0] tmp;
        logic [127:0] wb_d;
        logic [31:0]  exp_rd;
        bit           hit;
        bit           wb;
        int           lwb;
        int           lrf;
        int           exp_stall;
        line = a[29:2];
        idx  = a[4:2];
        tag  = a[29:5];
        off  = a[1:0];
        if (!backing.exists(line)) begin
            backing[line] = {$urandom, $urandom, $urandom, $urandom};
            truth[line]   = backing[line];
        end
        hit    = mv[idx] && (mtag[idx] == tag);
        wb     = !hit && mv[idx] && md[idx];
        victim = {mtag[idx], idx};
        wb_d   = wb ? truth[victim] : '0;
        lwb    = int'($urandom_range(1, 4));
        lrf    = int'($urandom_range(1, 4));
        exp_stall = hit ? 0 : 1 + (wb ? lwb : 0) + lrf;
        tmp    = truth[line];
        exp_rd = tmp[{off, 5'd0} +: 32];
        access(rd, wr, a, wd, lwb, lrf, backing[line], exp_stall, !wr, exp_rd, wb, victim, wb_d);
        if (wb) backing[victim] = truth[victim];
        if (!hit) md[idx] = 1'b0;
        mv[idx]   = 1'b1;
        mtag[idx] = tag;
        if (wr) begin
            tmp[{off, 5'd0} +: 32] = wd;
            truth[line] = tmp;
            md[idx]     = 1'b1;
        end
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 30'h3, 32'h0, 0, 3, 128'h4444_4444_3333_3333_2222_2222_1111_1111,
                   4, 1'b1, 32'h4444_4444, 1'b0, 28'h0, 128'h0};
        tbl[1] = '{1'b0, 1'b1, 30'h1, 32'hDEAD_BEEF, 0, 0, 128'h0,
                   0, 1'b0, 32'h0, 1'b0, 28'h0, 128'h0};
        tbl[2] = '{1'b1, 1'b0, 30'h1, 32'h0, 0, 0, 128'h0,
                   0, 1'b1, 32'hDEAD_BEEF, 1'b0, 28'h0, 128'h0};
        tbl[3] = '{1'b1, 1'b0, 30'h21, 32'h0, 2, 2, 128'hA3A3_A3A3_A2A2_A2A2_A1A1_A1A1_A0A0_A0A0,
                   5, 1'b1, 32'hA1A1_A1A1, 1'b1, 28'h0, 128'h4444_4444_3333_3333_DEAD_BEEF_1111_1111};
        tbl[4] = '{1'b1, 1'b0, 30'h1, 32'h0, 0, 2, 128'h5555_0003_5555_0002_5555_0001_5555_0000,
                   3, 1'b1, 32'h5555_0001, 1'b0, 28'h0, 128'h0};
        tbl[5] = '{1'b0, 1'b1, 30'h42, 32'h1234_5678, 0, 1, 128'h6666_0003_6666_0002_6666_0001_6666_0000,
                   2, 1'b0, 32'h0, 1'b0, 28'h0, 128'h0};
        tbl[6] = '{1'b1, 1'b0, 30'h2, 32'h0, 1, 4, 128'h7777_0003_7777_0002_7777_0001_7777_0000,
                   6, 1'b1, 32'h7777_0002, 1'b1, 28'h10, 128'h6666_0003_1234_5678_6666_0001_6666_0000};
        tbl[7] = '{1'b1, 1'b0, 30'h42, 32'h0, 0, 1, 128'h8888_0003_8888_0002_8888_0001_8888_0000,
                   2, 1'b1, 32'h8888_0002, 1'b0, 28'h0, 128'h0};

        do_reset();
        @(negedge clk);
        chk("reset_idle", 128'({proc_stall, mem_read, mem_write}), 128'b0);
        chk("reset_no_x", 128'($isunknown({proc_rdata, mem_addr, mem_wdata})), 128'b0);

        for (int i = 0; i < 4; i++) begin
            access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].lwb, tbl[i].lrf, tbl[i].rfd,
                   tbl[i].stall, tbl[i].chk_rd, tbl[i].rdata, tbl[i].wb, tbl[i].wb_a, tbl[i].wb_d);
        end
        for (int i = 0; i < 10; i++) idle_cycle();

        // Dirty line 0, start a conflicting read, then reset while the write-back is in flight
        access(1'b0, 1'b1, 30'h21, 32'hCAFE_F00D, 0, 0, 128'h0, 0, 1'b0, 32'h0, 1'b0, 28'h0, 128'h0);
        @(posedge clk); #1;
        proc_read  = 1'b1;
        proc_write = 1'b0;
        proc_addr  = 30'h1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_write) break;
            @(posedge clk); #1;
        end
        chk("wb_before_reset", 128'(mem_write), 128'b1);
        proc_reset = 1'b1;
        proc_read  = 1'b0;
        @(posedge clk); #1;
        proc_reset = 1'b0;
        @(negedge clk);
        chk("after_reset_mem", 128'({proc_stall, mem_read, mem_write}), 128'b0);

        for (int i = 4; i < 8; i++) begin
            access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].lwb, tbl[i].lrf, tbl[i].rfd,
                   tbl[i].stall, tbl[i].chk_rd, tbl[i].rdata, tbl[i].wb, tbl[i].wb_a, tbl[i].wb_d);
        end

        // Random traffic over 4 tags x 8 indices so conflicts and dirty evictions are frequent
        do_reset();
        model_clear();
        for (int n = 0; n < 300; n++) begin
            int unsigned r;
            logic wr;
            logic rd;
            r = $urandom_range(0, 9);
            if (r < 2) begin
                idle_cycle();
            end else begin
                wr = (r >= 6);
                rd = wr ? 1'($urandom) : 1'b1;
                rand_access(rd, wr, 30'($urandom_range(0, 127)), $urandom);
            end
        end

        @(posedge clk); #1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
